fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries; only 2 is supported.
REQ-003 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  output  1  fetch request to instruction memory.
REQ-006 Port: req_ready  input  1  memory accepts request; handshake when req_valid & req_ready.
REQ-007 Port: req_addr  output  32  word-aligned fetch address.
REQ-008 Port: resp_valid  input  1  memory response present; no backpressure, one response per accepted request, in order.
REQ-009 Port: resp_data  input  32  fetched instruction word.
REQ-010 Port: redirect_valid  input  1  branch/jump/trap redirect from execute; single-cycle pulse.
REQ-011 Port: redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-012 Port: inst_valid  output  1  buffered instruction offered to the decoder.
REQ-013 Port: inst_ready  input  1  decoder accepts; transfer when inst_valid & inst_ready.
REQ-014 Port: inst  output  32  instruction word, same format as the decoder's inst input.
REQ-015 Port: inst_pc  output  32  address of inst.

Function
REQ-016 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, inst}, and an FSM with the states IDLE (no request outstanding), WAIT (one live request outstanding), and DROP (one stale request outstanding).
REQ-017 At most one request SHALL be outstanding; req_valid = (state==IDLE) & !redirect_valid & (fifo_count + 0 < 2) & !reset, and req_valid is combinational and may deassert without a handshake.
REQ-018 req_addr SHALL equal the fetch PC; on a handshake the fetch PC SHALL become PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and the state SHALL go IDLE->WAIT.
REQ-019 An instruction SHALL be issued only if the FIFO has a free slot for its response: fifo_count < 2 at issue, with no pop credited in the same cycle.
REQ-020 WAIT with resp_valid and no redirect SHALL push {PC of the request, resp_data} into the FIFO and return to IDLE; inst_valid SHALL rise the next cycle (1-cycle response-to-decoder latency).
REQ-021 The minimum issue interval SHALL be 2 cycles (response cycle, then the next request from IDLE).
REQ-022 inst_valid SHALL be (fifo_count != 0); inst and inst_pc SHALL come from the FIFO head and remain stable while inst_valid & !inst_ready.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged, and entry order SHALL be preserved.
REQ-024 A redirect SHALL have priority over all other events: it flushes the FIFO (count=0, and any pop in the same cycle is ignored) and loads the fetch PC with {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect in IDLE: the state SHALL stay IDLE and the first request to the target SHALL be made the next cycle.
REQ-026 Redirect in WAIT without resp_valid: the state SHALL go to DROP.
REQ-027 Redirect in WAIT with resp_valid in the same cycle: the response SHALL be discarded and the state SHALL go to IDLE.
REQ-028 DROP SHALL issue no requests; resp_valid in DROP SHALL be discarded and the state SHALL go to IDLE.
REQ-029 Redirect in DROP SHALL update the fetch PC and keep the state DROP.
REQ-030 resp_valid in IDLE is a protocol violation; it SHALL be ignored and SHALL NOT push into the FIFO.

Reset
REQ-031 While reset is high, all of the following SHALL hold asynchronously: state=IDLE, fetch PC=RESET_PC, fifo_count=0, inst_valid=0, req_valid=0, and inst/inst_pc=0.
REQ-032 In the first cycle after reset deasserts, the block SHALL present req_valid=1 with req_addr=RESET_PC.
REQ-033 A reset asserted mid-operation SHALL abandon any outstanding request; responses arriving after reset release while in IDLE SHALL be ignored per REQ-030.

Verification
REQ-034 Reset release with req_ready=1 and resp_valid one cycle after each handshake: requests go to 0x0, 0x4, 0x8, every 2 cycles, and inst/inst_pc appear in order with inst_valid one cycle after each response.
REQ-035 Hold inst_ready=0: exactly 2 instructions are buffered, req_valid stays 0; one pop causes a new request the following cycle.
REQ-036 Redirect to 0x0000_1003 while WAIT, then resp_valid next cycle: the response is dropped, the next req_addr is 0x0000_1000, and no stale inst reaches the decoder.
REQ-037 Redirect and resp_valid in the same cycle, with 1 instruction buffered and inst_ready=1: the FIFO empties, inst_valid=0 the next cycle, and the request goes to the target.
REQ-038 Set the fetch PC to 0xFFFF_FFFC via redirect: the subsequent req_addr is 0x0000_0000.
REQ-039 Assert reset while in DROP with the FIFO full: all outputs go to reset values immediately, and after release req_addr=RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch front end: one outstanding memory request, a small
// {pc, inst} buffer toward the decoder, and redirect-driven flush/drop.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  fetch_ent_t      mem [DEPTH];
  fetch_ent_t      head;
  logic            handshake, push, pop;
  logic            unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Issue only when the response is guaranteed a slot; a same-cycle pop is not credited.
  assign req_valid  = (state == IDLE) & ~redirect_valid & (count < CW'(DEPTH)) & ~reset;
  assign req_addr   = pc;
  assign handshake  = req_valid & req_ready;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign push       = (state == WAIT) & resp_valid & ~redirect_valid;
  assign head       = mem[rd_ptr];
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (handshake) begin
          pc     <= pc + 32'd4;
          req_pc <= pc;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      // A response always retires the single outstanding request, live or stale.
      case (state)
        IDLE:    if (handshake) state <= WAIT;
        WAIT:    if (resp_valid) state <= IDLE;
                 else if (redirect_valid) state <= DROP;
        DROP:    if (resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{pc: req_pc, inst: resp_data};
  end
endmodule
